serial_slave_port: RTL

//  Responder end of the bit-serial system bus, the counterpart of the demo_master initiator.
//  It deserialises the address and write data a master shifts in on swdata/mvalid, and it

---
 rtl/serial_slave_port.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/serial_slave_port.sv
// Bit-serial bus responder: shifts in address/write data, drives a parallel memory port,
// and serialises read data back out LSB first.
module serial_slave_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  output logic                  srdata,
  output logic                  svalid,
  output logic                  sready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [2:0]            dbg_state
);

  localparam int CNT_MAX_AD = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_MAX    = (CNT_MAX_AD > RD_LATENCY) ? CNT_MAX_AD : RD_LATENCY;
  localparam int CW         = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, MEMWR, RDWAIT, RDATA} state_t;

  state_t                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [DATA_WIDTH-1:0]   wdata_d;
  logic [DATA_WIDTH-1:0]   tx_q, tx_d;
  logic                    srdata_d, svalid_d, sready_d, wen_d, ren_d;

  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      tx_q      <= '0;
      srdata    <= 1'b0;
      svalid    <= 1'b0;
      sready    <= 1'b1;
      mem_wen   <= 1'b0;
      mem_ren   <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      tx_q      <= tx_d;
      srdata    <= srdata_d;
      svalid    <= svalid_d;
      sready    <= sready_d;
      mem_wen   <= wen_d;
      mem_ren   <= ren_d;
    end
  end

  // Handshake: a swdata bit is consumed only in a cycle where mvalid=1 and the port is in
  // IDLE/ADDR/WDATA; svalid marks DATA_WIDTH consecutive srdata bits with no backpressure.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    addr_d   = mem_addr;
    wdata_d  = mem_wdata;
    tx_d     = tx_q;
    srdata_d = 1'b0;
    svalid_d = 1'b0;
    wen_d    = 1'b0;
    ren_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mvalid) begin
          addr_d    = '0;
          addr_d[0] = swdata;
          mode_d    = smode;
          cnt_d     = CW'(1);
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (mvalid) begin
          for (int i = 0; i < ADDR_WIDTH; i++)
            if (cnt_q == CW'(i)) addr_d[i] = swdata;
          if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
            cnt_d = '0;
            if (mode_q) begin
              state_d = WDATA;
            end else begin
              state_d = RDWAIT;
              ren_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      WDATA: begin
        if (mvalid) begin
          for (int i = 0; i < DATA_WIDTH; i++)
            if (cnt_q == CW'(i)) wdata_d[i] = swdata;
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            cnt_d   = '0;
            wen_d   = 1'b1;
            state_d = MEMWR;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      MEMWR: state_d = IDLE;
      RDWAIT: begin
        // cnt_q counts cycles since entry; read data is valid RD_LATENCY cycles after the strobe
        if (cnt_q == CW'(RD_LATENCY)) begin
          tx_d     = mem_rdata >> 1;
          srdata_d = mem_rdata[0];
          svalid_d = 1'b1;
          cnt_d    = '0;
          state_d  = RDATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RDATA: begin
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          srdata_d = tx_q[0];
          svalid_d = 1'b1;
          tx_d     = tx_q >> 1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    sready_d = (state_d == IDLE);
  end

endmodule
